route_compute_unit: RTL and testbench

- Routing stage directly downstream of the router's per-port input buffer.
- Watches the buffer's front flit and decodes head flits (XY dimension-order routing).
- Locks the chosen output port for the whole packet and drives Data_Request_Routing back to the buffer.
- Releases the route when the tail flit is consumed, i.e. on the cycle the switch allocator also grants.

---
 rtl/noc_pkg.sv | 44 ++++
 rtl/xy_route_calc.sv | 27 ++
 rtl/route_compute_unit.sv | 137 +++++++++++++
 tb/tb_route_compute_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, flit types, output port encoding.
package noc_pkg;

   localparam int unsigned FLIT_W    = 32;
   localparam int unsigned COORD_W   = 3;
   localparam int unsigned NUM_PORTS = 5;

   // Field positions inside a flit
   localparam int unsigned TYPE_HI = 31;
   localparam int unsigned TYPE_LO = 30;
   localparam int unsigned DX_HI   = 29;
   localparam int unsigned DX_LO   = 27;
   localparam int unsigned DY_HI   = 26;
   localparam int unsigned DY_LO   = 24;

   // One-hot output port bit positions
   localparam int unsigned PORT_L = 0;
   localparam int unsigned PORT_N = 1;
   localparam int unsigned PORT_E = 2;
   localparam int unsigned PORT_S = 3;
   localparam int unsigned PORT_W = 4;

   typedef enum logic [1:0] {
      FLIT_EMPTY = 2'b00,
      FLIT_HEAD  = 2'b01,
      FLIT_BODY  = 2'b10,
      FLIT_TAIL  = 2'b11
   } flit_type_e;

   // Flit as seen by the routing stage; dest fields are meaningful on heads only
   typedef struct packed {
      flit_type_e          ftype;
      logic [COORD_W-1:0]  dest_x;
      logic [COORD_W-1:0]  dest_y;
      logic [23:0]         payload;
   } flit_t;

   typedef enum logic [1:0] {
      RC_IDLE   = 2'b00,
      RC_ACTIVE = 2'b01,
      RC_DROP   = 2'b10
   } rc_state_e;

endpackage

// File: rtl/xy_route_calc.sv
// Combinational XY dimension-order route: resolve X first, then Y, else local.
module xy_route_calc
   import noc_pkg::*;
(
   input  logic [COORD_W-1:0]   dest_x,
   input  logic [COORD_W-1:0]   dest_y,
   input  logic [COORD_W-1:0]   router_x,
   input  logic [COORD_W-1:0]   router_y,
   output logic [NUM_PORTS-1:0] port_onehot_c
);

   // Pick exactly one output port from the unsigned coordinate comparison
   always_comb begin
      port_onehot_c = '0;
      if (dest_x > router_x)
         port_onehot_c[PORT_E] = 1'b1;
      else if (dest_x < router_x)
         port_onehot_c[PORT_W] = 1'b1;
      else if (dest_y > router_y)
         port_onehot_c[PORT_N] = 1'b1;
      else if (dest_y < router_y)
         port_onehot_c[PORT_S] = 1'b1;
      else
         port_onehot_c[PORT_L] = 1'b1;
   end

endmodule

// File: rtl/route_compute_unit.sv
// Per-input routing stage: decodes head flits, locks the output port for the
// packet, sinks stray body/tail flits and counts protocol errors.
module route_compute_unit
   import noc_pkg::*;
#(
   parameter int unsigned ROUTER_X  = 0,
   parameter int unsigned ROUTER_Y  = 0,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FLIT_W-1:0]     input_flit,
   input  logic                  Data_Request_Switching,
   output logic                  Data_Request_Routing,
   output logic [NUM_PORTS-1:0]  out_port,
   output logic                  drop_flit,
   output logic                  packet_active,
   output logic [ERR_CNT_W-1:0]  err_count
);

   rc_state_e             state_q, state_n;
   flit_t                 front;
   logic [NUM_PORTS-1:0]  route_c;
   logic                  consume;
   logic                  err_inc;
   logic                  head_pend_q, head_pend_n;
   logic                  drr_n, drop_n, act_n;
   logic [NUM_PORTS-1:0]  port_n;
   logic [ERR_CNT_W-1:0]  err_n;

   assign front   = flit_t'(input_flit);
   // The buffer pops on the negedge after a posedge seeing both request and grant
   assign consume = Data_Request_Switching & Data_Request_Routing;

   xy_route_calc u_xy_route_calc (
      .dest_x        (front.dest_x),
      .dest_y        (front.dest_y),
      .router_x      (COORD_W'(ROUTER_X)),
      .router_y      (COORD_W'(ROUTER_Y)),
      .port_onehot_c (route_c)
   );

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q              <= RC_IDLE;
         head_pend_q          <= 1'b0;
         Data_Request_Routing <= 1'b0;
         out_port             <= '0;
         drop_flit            <= 1'b0;
         packet_active        <= 1'b0;
         err_count            <= '0;
      end else begin
         state_q              <= state_n;
         head_pend_q          <= head_pend_n;
         Data_Request_Routing <= drr_n;
         out_port             <= port_n;
         drop_flit            <= drop_n;
         packet_active        <= act_n;
         err_count            <= err_n;
      end
   end

   // Next state and next output values
   always_comb begin
      state_n     = state_q;
      head_pend_n = head_pend_q;
      drr_n       = 1'b0;
      port_n      = out_port;
      drop_n      = 1'b0;
      act_n       = 1'b0;
      err_inc     = 1'b0;

      unique case (state_q)
         RC_IDLE: begin
            port_n      = '0;
            head_pend_n = 1'b0;
            unique case (front.ftype)
               FLIT_HEAD: begin
                  state_n     = RC_ACTIVE;
                  port_n      = route_c;
                  drr_n       = 1'b1;
                  act_n       = 1'b1;
                  head_pend_n = 1'b1;
               end
               FLIT_BODY, FLIT_TAIL: begin
                  state_n = RC_DROP;
                  drop_n  = 1'b1;
                  drr_n   = 1'b1;
                  err_inc = 1'b1;
               end
               default: ;
            endcase
         end

         RC_ACTIVE: begin
            act_n = 1'b1;
            drr_n = (front.ftype != FLIT_EMPTY);
            if (consume) begin
               // First consume of a packet is its own head; later heads are errors
               head_pend_n = 1'b0;
               if (front.ftype == FLIT_TAIL) begin
                  state_n = RC_IDLE;
                  port_n  = '0;
                  drr_n   = 1'b0;
                  act_n   = 1'b0;
               end else if ((front.ftype == FLIT_HEAD) && !head_pend_q) begin
                  err_inc = 1'b1;
               end
            end
         end

         RC_DROP: begin
            port_n = '0;
            if (consume) begin
               state_n = RC_IDLE;
            end else begin
               drop_n = 1'b1;
               drr_n  = 1'b1;
            end
         end

         default: begin
            state_n     = RC_IDLE;
            port_n      = '0;
            head_pend_n = 1'b0;
         end
      endcase

      // Saturating protocol-error counter
      if (err_inc && (err_count != {ERR_CNT_W{1'b1}}))
         err_n = err_count + ERR_CNT_W'(1);
      else
         err_n = err_count;
   end

endmodule

// File: tb/tb_route_compute_unit.sv
// Scoreboard bench for route_compute_unit at router (2,2).
module tb_route_compute_unit;

   logic        clk;
   logic        rst;
   logic [31:0] input_flit;
   logic        grant;
   logic        drr;
   logic [4:0]  out_port;
   logic        drop_flit;
   logic        packet_active;
   logic [7:0]  err_count;

   typedef struct packed {
      logic       drr;
      logic [4:0] port;
      logic       drop;
      logic       act;
      logic [7:0] err;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks;
   int    errors;

   localparam logic [31:0] BODY  = 32'h8000_0000;
   localparam logic [31:0] TAIL  = 32'hC000_0000;
   localparam logic [31:0] EMPTY = 32'h0000_0000;

   route_compute_unit #(
      .ROUTER_X  (2),
      .ROUTER_Y  (2),
      .ERR_CNT_W (8)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .input_flit             (input_flit),
      .Data_Request_Switching (grant),
      .Data_Request_Routing   (drr),
      .out_port               (out_port),
      .drop_flit              (drop_flit),
      .packet_active          (packet_active),
      .err_count              (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mk_head(input int x, input int y);
      mk_head = {2'b01, 3'(x), 3'(y), 24'h0};
   endfunction

   function automatic exp_t mk_exp(input logic d, input logic [4:0] p, input logic dr,
                                    input logic a, input int e);
      mk_exp = '{drr: d, port: p, drop: dr, act: a, err: 8'(e)};
   endfunction

   // Drive one cycle of inputs and queue the outputs expected after the next posedge
   task automatic step(input string nm, input logic [31:0] f, input logic g, input exp_t e);
      @(negedge clk);
      input_flit = f;
      grant      = g;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Direct comparison of the live outputs (used across async reset)
   task automatic check_now(input string nm, input exp_t e);
      exp_t act;
      act = '{drr: drr, port: out_port, drop: drop_flit, act: packet_active, err: err_count};
      checks++;
      if (act !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, e);
      end
   endtask

   // Monitor: compare registered outputs shortly after each edge that has an expectation
   always @(posedge clk) begin
      #2;
      if (exp_q.size() > 0) begin
         exp_t  e;
         exp_t  act;
         string nm;
         e   = exp_q.pop_front();
         nm  = name_q.pop_front();
         act = '{drr: drr, port: out_port, drop: drop_flit, act: packet_active, err: err_count};
         checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL %s: got drr=%b port=%b drop=%b act=%b err=%0d expected drr=%b port=%b drop=%b act=%b err=%0d",
                     nm, act.drr, act.port, act.drop, act.act, act.err,
                     e.drr, e.port, e.drop, e.act, e.err);
         end
      end
   end

   initial begin
      int wait_cycles;
      checks     = 0;
      errors     = 0;
      rst        = 1'b1;
      input_flit = EMPTY;
      grant      = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_now("reset_state", mk_exp(0, 5'b00000, 0, 0, 0));
      rst = 1'b0;

      // Packet to (5,1): east, three consumes, back to idle
      step("t1_head",      mk_head(5, 1), 1, mk_exp(1, 5'b00100, 0, 1, 0));
      step("t1_head_cons", mk_head(5, 1), 1, mk_exp(1, 5'b00100, 0, 1, 0));
      step("t1_body_cons", BODY,          1, mk_exp(1, 5'b00100, 0, 1, 0));
      step("t1_tail_cons", TAIL,          1, mk_exp(0, 5'b00000, 0, 0, 0));
      step("t1_idle",      EMPTY,         0, mk_exp(0, 5'b00000, 0, 0, 0));

      // Local packet with grant withheld for 4 cycles
      step("t2_head", mk_head(2, 2), 0, mk_exp(1, 5'b00001, 0, 1, 0));
      for (int i = 0; i < 4; i++)
         step("t2_hold", mk_head(2, 2), 0, mk_exp(1, 5'b00001, 0, 1, 0));
      step("t2_head_cons", mk_head(2, 2), 1, mk_exp(1, 5'b00001, 0, 1, 0));
      step("t2_tail_cons", TAIL,          1, mk_exp(0, 5'b00000, 0, 0, 0));
      step("t2_idle",      EMPTY,         0, mk_exp(0, 5'b00000, 0, 0, 0));

      // Stray tail in idle is dropped and counted
      step("t3_drop",      TAIL,  0, mk_exp(1, 5'b00000, 1, 0, 1));
      step("t3_drop_hold", TAIL,  0, mk_exp(1, 5'b00000, 1, 0, 1));
      step("t3_drop_cons", TAIL,  1, mk_exp(0, 5'b00000, 0, 0, 1));
      step("t3_idle",      EMPTY, 0, mk_exp(0, 5'b00000, 0, 0, 1));

      // Packet to (0,4): west, with a 3-cycle empty gap mid-packet
      step("t4_head",      mk_head(0, 4), 1, mk_exp(1, 5'b10000, 0, 1, 1));
      step("t4_head_cons", mk_head(0, 4), 1, mk_exp(1, 5'b10000, 0, 1, 1));
      step("t4_body_cons", BODY,          1, mk_exp(1, 5'b10000, 0, 1, 1));
      for (int i = 0; i < 3; i++)
         step("t4_gap", EMPTY, 0, mk_exp(0, 5'b10000, 0, 1, 1));
      step("t4_resume",    BODY,  0, mk_exp(1, 5'b10000, 0, 1, 1));
      step("t4_body2_cons",BODY,  1, mk_exp(1, 5'b10000, 0, 1, 1));
      step("t4_tail_cons", TAIL,  1, mk_exp(0, 5'b00000, 0, 0, 1));

      // Head-before-tail mid-packet counts an error but keeps the route
      step("t4b_head",       mk_head(7, 0), 1, mk_exp(1, 5'b00100, 0, 1, 1));
      step("t4b_head_cons",  mk_head(7, 0), 1, mk_exp(1, 5'b00100, 0, 1, 1));
      step("t4b_head2_cons", mk_head(0, 0), 1, mk_exp(1, 5'b00100, 0, 1, 2));
      step("t4b_tail_cons",  TAIL,          1, mk_exp(0, 5'b00000, 0, 0, 2));

      // Async reset mid-packet, then a fresh packet routes north
      step("t5_head",      mk_head(4, 4), 1, mk_exp(1, 5'b00100, 0, 1, 2));
      step("t5_head_cons", mk_head(4, 4), 1, mk_exp(1, 5'b00100, 0, 1, 2));
      step("t5_body_cons", BODY,          1, mk_exp(1, 5'b00100, 0, 1, 2));
      @(negedge clk);
      input_flit = BODY;
      grant      = 1'b1;
      #1 rst = 1'b1;
      #1 check_now("t5_async_reset", mk_exp(0, 5'b00000, 0, 0, 0));
      exp_q.push_back(mk_exp(0, 5'b00000, 0, 0, 0));
      name_q.push_back("t5_in_reset");
      @(negedge clk);
      rst        = 1'b0;
      input_flit = EMPTY;
      grant      = 1'b0;
      step("t5n_head",      mk_head(2, 3), 1, mk_exp(1, 5'b00010, 0, 1, 0));
      step("t5n_head_cons", mk_head(2, 3), 1, mk_exp(1, 5'b00010, 0, 1, 0));
      step("t5n_tail_cons", TAIL,          1, mk_exp(0, 5'b00000, 0, 0, 0));

      // 300 stray tails: counter saturates at 255
      for (int i = 1; i <= 300; i++) begin
         int e;
         e = (i > 255) ? 255 : i;
         step("t6_drop", TAIL, 1, mk_exp(1, 5'b00000, 1, 0, e));
         step("t6_cons", TAIL, 1, mk_exp(0, 5'b00000, 0, 0, e));
      end
      step("t6_final", EMPTY, 0, mk_exp(0, 5'b00000, 0, 0, 255));

      // Drain the scoreboard with a bounded wait
      wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 100) begin
         @(posedge clk);
         wait_cycles++;
      end
      #5;
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
